// File: rtl/cic_comb_decimator_if.sv
// cic_comb_decimator_if: full-rate sample stream in, decimated comb result out.
interface cic_comb_decimator_if #(
  parameter int IDW = 9,
  parameter int ODW = 9
);
  logic in_valid;
  logic [IDW-1:0] data_in;
  logic dec_sync;
  logic out_valid;
  logic [ODW-1:0] data_out;
  modport master(output in_valid, data_in, dec_sync, input out_valid, data_out);
  modport slave(input in_valid, data_in, dec_sync, output out_valid, data_out);
endinterface

// File: rtl/cic_comb_decimator.sv
// cic_comb_decimator: keeps one sample in R and runs it through N modular comb stages.
module cic_comb_decimator #(
  parameter int IDW = 9,
  parameter int ODW = 9,
  parameter int N = 3,
  parameter int M = 1,
  parameter int R = 8
) (
  input logic clk,
  input logic reset_n,
  cic_comb_decimator_if.slave bus
);
  localparam int CW = $clog2(R);
  localparam int P = N * M;
  localparam int PW = $clog2(P + 1);
  localparam int S = IDW - ODW;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pc;
  logic [N-1:0] v;
  logic [IDW-1:0] x [N];
  logic [IDW-1:0] d [N][M];
  logic [ODW-1:0] top;
  logic acc;
  assign acc = bus.in_valid && (bus.dec_sync || cnt == '0);
  // Top ODW bits of the last difference, with the borrow from the dropped low bits folded in
  generate
    if (S == 0) begin : g_full
      assign top = x[N-1] - d[N-1][M-1];
    end else begin : g_trunc
      assign top = x[N-1][IDW-1 -: ODW] - d[N-1][M-1][IDW-1 -: ODW]
                   - ODW'(x[N-1][S-1:0] < d[N-1][M-1][S-1:0]);
    end
  endgenerate
  always_ff @(posedge clk)
    if (!reset_n) begin
      cnt <= '0;
      pc <= '0;
      v <= '0;
      bus.out_valid <= 1'b0;
      bus.data_out <= '0;
      for (int k = 0; k < N; k++) begin
        x[k] <= '0;
        for (int j = 0; j < M; j++) d[k][j] <= '0;
      end
    end else begin
      if (bus.in_valid) cnt <= bus.dec_sync ? CW'(1) : (cnt == CW'(R - 1) ? '0 : cnt + 1'b1);
      else if (bus.dec_sync) cnt <= '0;
      v[0] <= acc;
      for (int k = 1; k < N; k++) v[k] <= v[k-1];
      if (acc) x[0] <= bus.data_in;
      for (int k = 1; k < N; k++) if (v[k-1]) x[k] <= x[k-1] - d[k-1][M-1];
      for (int k = 0; k < N; k++)
        if (v[k]) begin
          d[k][0] <= x[k];
          for (int j = 1; j < M; j++) d[k][j] <= d[k][j-1];
        end
      bus.out_valid <= v[N-1] && pc == PW'(P);
      if (v[N-1]) begin
        if (pc == PW'(P)) bus.data_out <= top;
        else pc <= pc + 1'b1;
      end
    end
endmodule
